// File: rtl/hamming_counter.sv
// hamming_counter
//   Free-running 26-bit event counter. The count is kept alongside its
//   32-bit extended Hamming (SECDED) codeword, and only the codeword is
//   visible outside the block.
//
// Ports
//   clk     in   1  single clock, all state updates on its rising edge
//   rst     in   1  asynchronous active-high reset, clears count and codeword
//   enable  in   1  count-enable, sampled on the rising edge of clk
//   counter out 32  registered extended Hamming codeword of the count
//
// Codeword layout: bit i is Hamming position i for i = 1..31. Parity bits
// sit at positions 1, 2, 4, 8 and 16. Bit 0 holds the overall parity, so
// the full word always has even weight.
module hamming_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] counter
);

  logic [25:0] count_q;
  logic [25:0] count_d;
  logic [31:0] counter_q;
  logic [31:0] counter_d;

  // Place the data onto the non-power-of-two positions, then generate the
  // parity bits. Each mask selects every position whose index has bit k
  // set. A parity bit is still zero when its own mask covers it, so it does
  // not feed back into itself. Earlier parity bits fall outside later masks.
  function automatic logic [31:0] encode(input logic [25:0] d);
    logic [31:0] w;
    w        = 32'h0000_0000;
    w[3]     = d[0];
    w[7:5]   = d[3:1];
    w[15:9]  = d[10:4];
    w[31:17] = d[25:11];
    w[1]     = ^(w & 32'hAAAA_AAAA);
    w[2]     = ^(w & 32'hCCCC_CCCC);
    w[4]     = ^(w & 32'hF0F0_F0F0);
    w[8]     = ^(w & 32'hFF00_FF00);
    w[16]    = ^(w & 32'hFFFF_0000);
    w[0]     = ^w[31:1];
    return w;
  endfunction

  // Next-state: increment and re-encode when enabled, otherwise hold both.
  // The increment wraps naturally at 26 bits.
  always_comb begin
    count_d   = count_q;
    counter_d = counter_q;
    if (enable) begin
      count_d   = count_q + 26'd1;
      counter_d = encode(count_q + 26'd1);
    end else begin
      count_d   = count_q;
      counter_d = counter_q;
    end
  end

  // State registers. encode(0) is all zeros, so reset keeps the pair
  // consistent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 26'd0;
      counter_q <= 32'h0000_0000;
    end else begin
      count_q   <= count_d;
      counter_q <= counter_d;
    end
  end

  assign counter = counter_q;

endmodule

// File: tb/tb_hamming_counter.sv
module tb_hamming_counter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] counter;

  int unsigned mcount;
  int          n_cmp;
  int          n_err;
  logic [31:0] wrap_word;

  hamming_counter dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .counter (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder. It walks the Hamming positions, places the data bits
  // in ascending order, and accumulates the syndrome of the data. Setting
  // the parity bits to that syndrome makes the total syndrome zero.
  function automatic logic [31:0] ref_encode(input int unsigned v);
    logic [31:0] w;
    int          j;
    int          syn;
    w   = 32'h0;
    j   = 0;
    syn = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (((v >> j) & 1) == 1) begin
          w[p] = 1'b1;
          syn  = syn ^ p;
        end
        j++;
      end
    end
    for (int k = 0; k < 5; k++)
      if (((syn >> k) & 1) == 1) w[1 << k] = 1'b1;
    w[0] = (($countones(w[31:1]) % 2) == 1);
    return w;
  endfunction

  function automatic logic [31:0] syndrome_of(input logic [31:0] w);
    int s;
    s = 0;
    for (int p = 1; p < 32; p++) if (w[p]) s = s ^ p;
    return 32'(s);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w);
    logic [31:0] d;
    int          j;
    d = 32'h0;
    j = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = w[p];
        j++;
      end
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_parity"},   32'($countones(counter) % 2), 32'd0);
    chk({tag, "_syndrome"}, syndrome_of(counter), 32'd0);
    chk({tag, "_data"},     extract(counter), mcount);
    chk({tag, "_word"},     counter, ref_encode(mcount));
  endtask

  // One clock cycle with the given enable, entered and left at a falling edge.
  task automatic step(input logic en);
    enable = en;
    @(posedge clk);
    if (en && !rst) mcount = (mcount + 1) & 32'h03FF_FFFF;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    chk("rst_immediate", counter, 32'h0000_0000);
    rst = 1'b0;
    mcount = 0;
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    mcount = 0;
    rst    = 1'b1;
    enable = 1'b1;
    #3;
    chk("reset_initial", counter, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_held", counter, 32'h0000_0000);
    end
    rst = 1'b0;
    #1;
    chk("reset_release", counter, 32'h0000_0000);

    // First codewords
    step(1'b1); chk("first_1", counter, 32'h0000_000F);
    step(1'b1); chk("first_2", counter, 32'h0000_0033);
    step(1'b1); chk("first_3", counter, 32'h0000_003C);

    // Run and hold
    reset_pulse();
    for (int i = 0; i < 20; i++) step(1'b1);
    chk("run20", counter, 32'h0000_0356);
    for (int i = 0; i < 9; i++) begin
      step(1'b0);
      chk("hold", counter, 32'h0000_0356);
    end
    for (int i = 0; i < 5; i++) step(1'b1);
    chk("run25", counter, 32'h0000_039A);

    // Asynchronous reset mid-count
    reset_pulse();
    for (int i = 0; i < 20; i++) step(1'b1);
    chk("pre_async", counter, 32'h0000_0356);
    #2;
    rst = 1'b1;
    #1;
    chk("async_assert", counter, 32'h0000_0000);
    rst = 1'b0;
    mcount = 0;
    #1;
    chk("async_release", counter, 32'h0000_0000);
    enable = 1'b1;
    @(posedge clk);
    mcount = 1;
    @(negedge clk);
    chk("async_first", counter, 32'h0000_000F);

    // Wrap-around from a preloaded count
    enable    = 1'b0;
    wrap_word = ref_encode(32'h03FF_FFFE);
    force dut.count_q   = 26'h3FF_FFFE;
    force dut.counter_q = wrap_word;
    #1;
    release dut.count_q;
    release dut.counter_q;
    mcount = 32'h03FF_FFFE;
    step(1'b1); chk("wrap_max", counter, 32'hFFFF_FFFF);
    step(1'b1); chk("wrap_zero", counter, 32'h0000_0000);

    // Random enable pattern with enable glitches and occasional resets
    for (int i = 0; i < 1200; i++) begin
      logic en;
      en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) reset_pulse();
      enable = ~en;
      #1;
      enable = en;
      step(en);
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
